// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_op_e    : 4-bit opcode map, unchanged from the combinational breadboard ALU
//   ERR_*       : encodings of the 2-bit error_o field
//   alu_state_e : control FSM states of seq_alu
//   is_div_op   : true for the opcodes served by the iterative divider
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_DIV   = 4'b0010,
    OP_MOD   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_NAND  = 4'b0101,
    OP_OR    = 4'b0110,
    OP_NOR   = 4'b0111,
    OP_NOT   = 4'b1000,
    OP_NOOP  = 4'b1001,
    OP_XOR   = 4'b1010,
    OP_XNOR  = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_RSV_D = 4'b1101,
    OP_RSV_E = 4'b1110,
    OP_RSV_F = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor; the first quotient bit is produced on
//               the same edge, the remaining WIDTH-1 on the following edges
//   dividend  : WIDTH-bit dividend (sampled only with start)
//   divisor   : WIDTH-bit divisor, must be non-zero (sampled only with start)
//   busy      : iterations in progress
//   done      : one-cycle pulse, quotient/remainder valid from then on
//   quotient  : WIDTH-bit quotient
//   remainder : WIDTH-bit remainder
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] step_rem, step_quo;

  always_comb begin
    // On start the step works on the fresh operands so the first bit is not
    // lost to a separate load cycle.
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvs  = start ? divisor : dvs_q;
    trial    = {src_rem, src_quo[WIDTH-1]};
    fits     = (trial >= {1'b0, src_dvs});
    // When fits is set the true difference is below the divisor, so the
    // low WIDTH bits of the modular subtraction are exact.
    diff     = trial[WIDTH-1:0] - src_dvs;
    step_rem = fits ? diff : trial[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], fits};

    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;

    if (start) begin
      busy_d  = 1'b1;
      count_d = CW'(1);
      rem_d   = step_rem;
      quo_d   = step_quo;
      dvs_d   = divisor;
    end else if (busy_q) begin
      rem_d   = step_rem;
      quo_d   = step_quo;
      count_d = count_q + CW'(1);
      if (count_q + CW'(1) == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with registered operands, valid/ready on both sides and an
// iterative divider for DIV/MOD.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operation handshake (a_i, b_i, opcode_i)
//   out_valid/out_ready : result handshake (result_o, error_o)
//   result_o          : 2*WIDTH-bit result
//   error_o           : [0] signed overflow, [1] divide by zero, 11 illegal
// Optional feature macro: ALU_MUL_EN enables opcode 1100 as a signed
// WIDTHxWIDTH multiply; without it 1100 is an illegal opcode.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid/result_o/error_o are held
// until the edge where out_ready is seen with out_valid, after which the block
// is back in IDLE and in_ready rises the cycle after.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [3:0]         opcode_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result_o,
  output logic [1:0]         error_o
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [1:0]         error_q, error_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               div_start, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [WIDTH-1:0]   sum, dif;
  logic [2*WIDTH-1:0] calc_res;
  logic [1:0]         calc_err;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  assign accept    = in_valid && in_ready;
  // The divider is loaded straight from the inputs on the accept edge so that
  // EXEC spans exactly WIDTH cycles for DIV/MOD.
  assign div_start = accept && is_div_op(opcode_i) && (b_i != '0);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a_i),
    .divisor   (b_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Single-cycle operations, evaluated on the captured operands.
  always_comb begin
    sum      = a_q + b_q;
    dif      = a_q - b_q;
    calc_res = '0;
    calc_err = ERR_NONE;
`ifdef ALU_MUL_EN
    prod = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
`endif
    case (op_q)
      OP_ADD: begin
        calc_res = {{WIDTH{sum[WIDTH-1]}}, sum};
        if ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1])) calc_err = ERR_OVF;
      end
      OP_SUB: begin
        calc_res = {{WIDTH{dif[WIDTH-1]}}, dif};
        if ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1])) calc_err = ERR_OVF;
      end
      // Reached only with a zero divisor; non-zero divisors go to the divider.
      OP_DIV, OP_MOD: calc_err = ERR_DIV0;
      OP_AND:  calc_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_NAND: calc_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OP_OR:   calc_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_NOR:  calc_res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OP_NOT:  calc_res = {{WIDTH{1'b0}}, ~a_q};
      OP_NOOP: calc_res = {{WIDTH{1'b0}}, a_q};
      OP_XOR:  calc_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_XNOR: calc_res = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
`ifdef ALU_MUL_EN
      OP_MUL:  calc_res = prod;
`endif
      default: calc_err = ERR_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    error_d     = error_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = opcode_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_div_op(op_q) && (b_q != '0)) begin
          if (div_done) begin
            result_d    = {{WIDTH{1'b0}}, (op_q == OP_DIV) ? div_quo : div_rem};
            error_d     = ERR_NONE;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          result_d    = calc_res;
          error_d     = calc_err;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      error_q     <= ERR_NONE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      error_q     <= error_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The divider is idle whenever the FSM is in IDLE; the busy term only keeps
  // a stray start from overlapping an iteration.
  assign in_ready  = (state_q == IDLE) && !div_busy;
  assign out_valid = out_valid_q;
  assign result_o  = result_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 with hand-computed expected values.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_alu;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic [3:0]     opcode_i;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result_o;
  logic [1:0]     error_o;

  int checks;
  int errors;
  int lat;
  logic saw_valid;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .opcode_i  (opcode_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_o  (result_o),
    .error_o   (error_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the operation is accepted on the next
  // rising edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    check("issue_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    a_i      = a;
    b_i      = b;
    opcode_i = op;
    @(posedge clk);
  endtask

  // Counts falling edges after the accept edge until out_valid is seen.
  // Inputs are scrambled right after acceptance to show they are not used.
  task automatic wait_result(output int l);
    l = 0;
    while (l < 100) begin
      @(negedge clk);
      l++;
      if (l == 1) begin
        in_valid = 1'b0;
        a_i      = $urandom;
        b_i      = $urandom;
        opcode_i = 4'($urandom_range(0, 15));
      end
      if (out_valid) break;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_out_valid", {63'd0, out_valid}, 64'd0);
    check("after_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp_res,
                        input logic [1:0] exp_err, input int exp_lat);
    issue(op, a, b);
    wait_result(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_err"}, {62'd0, error_o}, {62'd0, exp_err});
    check({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    handoff();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    saw_valid = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_i       = '0;
    b_i       = '0;
    opcode_i  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_error", {62'd0, error_o}, 64'd0);

    // signed add/sub with overflow, sign-extended
    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 2'b01, 2);
    run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'h0000_0001, 64'h0000_0000_7FFF_FFFF, 2'b01, 2);

    // SUB with the consumer stalling for 5 cycles
    issue(4'b0001, 32'd2, 32'd4);
    wait_result(lat);
    check("sub_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("sub_hold_res", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_hold_err", {62'd0, error_o}, 64'd0);
      check("sub_hold_valid", {63'd0, out_valid}, 64'd1);
      check("sub_hold_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    handoff();

    // divider
    run_op("div", 4'b0010, 32'h0700_0002, 32'd2, 64'h0000_0000_0380_0001, 2'b00, 33);
    run_op("mod", 4'b0011, 32'h0780_0007, 32'd4, 64'd3, 2'b00, 33);
    run_op("div_small", 4'b0010, 32'd5, 32'd7, 64'd0, 2'b00, 33);
    run_op("mod_small", 4'b0011, 32'd5, 32'd7, 64'd5, 2'b00, 33);
    run_op("div_by1", 4'b0010, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 2'b00, 33);
    run_op("mod_by1", 4'b0011, 32'hFFFF_FFFF, 32'd1, 64'd0, 2'b00, 33);
    run_op("div_max", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'd1, 2'b00, 33);
    run_op("mod_max", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'd1, 2'b00, 33);
    run_op("div_zero", 4'b0010, 32'd4, 32'd0, 64'd0, 2'b10, 2);
    run_op("mod_zero", 4'b0011, 32'd4, 32'd0, 64'd0, 2'b10, 2);

    // logic ops, zero-extended
    run_op("nand", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 2'b00, 2);
    run_op("or", 4'b0110, 32'hF0F0_0000, 32'h0F00_00FF, 64'h0000_0000_FFF0_00FF, 2'b00, 2);
    run_op("nor", 4'b0111, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFFF, 2'b00, 2);
    run_op("not", 4'b1000, 32'hF0F0_1234, 32'd0, 64'h0000_0000_0F0F_EDCB, 2'b00, 2);
    run_op("noop", 4'b1001, 32'h8000_0000, 32'd9, 64'h0000_0000_8000_0000, 2'b00, 2);
    run_op("xor", 4'b1010, 32'hFFFF_0000, 32'h0FF0_0FF0, 64'h0000_0000_F00F_0FF0, 2'b00, 2);
    run_op("xnor", 4'b1011, 32'h1234_5678, 32'h1234_5678, 64'h0000_0000_FFFF_FFFF, 2'b00, 2);

    // illegal and optional opcodes
    run_op("op_1101", 4'b1101, 32'd4, 32'd5, 64'd0, 2'b11, 2);
    run_op("op_1111", 4'b1111, 32'd1, 32'd1, 64'd0, 2'b11, 2);
`ifdef ALU_MUL_EN
    run_op("mul", 4'b1100, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 2'b00, 2);
`else
    run_op("op_1100", 4'b1100, 32'hFFFF_FFFD, 32'd7, 64'd0, 2'b11, 2);
`endif

    // reset during cycle 10 of a DIV aborts it
    issue(4'b0010, 32'h0700_0002, 32'd2);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_result", result_o, 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_result", {63'd0, saw_valid}, 64'd0);

    // AND after the abort, consumer always ready: DONE lasts one cycle
    out_ready = 1'b1;
    issue(4'b0100, 32'h0000_00DB, 32'h0000_006D);
    wait_result(lat);
    check("and_lat", 64'(lat), 64'd2);
    check("and_res", result_o, 64'h0000_0000_0000_0049);
    check("and_err", {62'd0, error_o}, 64'd0);
    @(negedge clk);
    check("and_done_1cyc", {63'd0, out_valid}, 64'd0);
    check("and_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
